// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register with valid/ready handshake, stall, flush, optional
// 2-entry skid buffer and a write-back mux on the registered fields.
module mem_wb_pipe_reg #(
   parameter int unsigned DATA_W            = 32,
   parameter int unsigned REG_ADDR_W        = 5,
   parameter int unsigned SKID              = 1,
   parameter int unsigned ZERO_REG_SUPPRESS = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_reg_write,
   input  logic                  in_mem_to_reg,
   input  logic [REG_ADDR_W-1:0] in_write_reg,
   input  logic [DATA_W-1:0]     in_alu_result,
   input  logic [DATA_W-1:0]     in_read_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_reg_write,
   output logic                  out_mem_to_reg,
   output logic [REG_ADDR_W-1:0] out_write_reg,
   output logic [DATA_W-1:0]     out_alu_result,
   output logic [DATA_W-1:0]     out_read_data,
   output logic [DATA_W-1:0]     out_wb_data
);

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [REG_ADDR_W-1:0] write_reg;
      logic [DATA_W-1:0]     alu_result;
      logic [DATA_W-1:0]     read_data;
   } entry_t;

   entry_t h_q, h_d;
   entry_t s_q, s_d;
   entry_t in_entry;
   logic   in_fire;
   logic   out_fire;

   assign in_entry = '{valid:      1'b1,
                       reg_write:  in_reg_write,
                       mem_to_reg: in_mem_to_reg,
                       write_reg:  in_write_reg,
                       alu_result: in_alu_result,
                       read_data:  in_read_data};

   // With the skid entry, in_ready depends only on state, breaking the
   // combinational path from out_ready back upstream.
   assign in_ready = (SKID != 0) ? ~s_q.valid : (~h_q.valid | out_ready);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = h_q.valid & out_ready;

   always_comb begin
      // NOTE: every variable gets a default first so no path through the
      // block leaves it unassigned, which would infer a latch.
      h_d = h_q;
      s_d = s_q;
      if (!h_q.valid || out_fire) begin
         if (s_q.valid) begin
            h_d       = s_q;
            s_d.valid = 1'b0;
         end else if (in_fire) begin
            h_d = in_entry;
         end else begin
            h_d.valid = 1'b0;
         end
      end else if (in_fire && (SKID != 0)) begin
         s_d = in_entry;
      end
      if (flush) begin
         h_d.valid = 1'b0;
         s_d.valid = 1'b0;
      end
      if (SKID == 0) begin
         s_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: data fields are reset too, so out_wb_data reads 0 after reset
      // rather than whatever the flops powered up with.
      if (reset) begin
         h_q <= '0;
         s_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         h_q <= h_d;
         s_q <= s_d;
      end
   end

   assign out_valid      = h_q.valid;
   assign out_reg_write  = h_q.valid & h_q.reg_write &
                           ~((ZERO_REG_SUPPRESS != 0) && (h_q.write_reg == '0));
   assign out_mem_to_reg = h_q.mem_to_reg;
   assign out_write_reg  = h_q.write_reg;
   assign out_alu_result = h_q.alu_result;
   assign out_read_data  = h_q.read_data;
   assign out_wb_data    = h_q.mem_to_reg ? h_q.read_data : h_q.alu_result;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench: instance a uses the skid buffer with r0 suppression,
// instance b is the single-entry variant without suppression.
module tb_mem_wb_pipe_reg;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_reg_write;
   logic        in_mem_to_reg;
   logic [4:0]  in_write_reg;
   logic [31:0] in_alu_result;
   logic [31:0] in_read_data;

   logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a;
   logic        out_reg_write_a, out_mem_to_reg_a;
   logic [4:0]  out_write_reg_a;
   logic [31:0] out_alu_result_a, out_read_data_a, out_wb_data_a;

   logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
   logic        out_reg_write_b, out_mem_to_reg_b;
   logic [4:0]  out_write_reg_b;
   logic [31:0] out_alu_result_b, out_read_data_b, out_wb_data_b;

   int checks;
   int errors;

   mem_wb_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .SKID(1), .ZERO_REG_SUPPRESS(1)) dut_a (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
      .in_write_reg(in_write_reg), .in_alu_result(in_alu_result),
      .in_read_data(in_read_data),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_reg_write(out_reg_write_a), .out_mem_to_reg(out_mem_to_reg_a),
      .out_write_reg(out_write_reg_a), .out_alu_result(out_alu_result_a),
      .out_read_data(out_read_data_a), .out_wb_data(out_wb_data_a)
   );

   mem_wb_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .SKID(0), .ZERO_REG_SUPPRESS(0)) dut_b (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
      .in_write_reg(in_write_reg), .in_alu_result(in_alu_result),
      .in_read_data(in_read_data),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_reg_write(out_reg_write_b), .out_mem_to_reg(out_mem_to_reg_b),
      .out_write_reg(out_write_reg_b), .out_alu_result(out_alu_result_b),
      .out_read_data(out_read_data_b), .out_wb_data(out_wb_data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic rw, input logic m2r, input logic [4:0] wr,
                         input logic [31:0] alu, input logic [31:0] rd);
      in_reg_write  = rw;
      in_mem_to_reg = m2r;
      in_write_reg  = wr;
      in_alu_result = alu;
      in_read_data  = rd;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      flush = 1'b0;
      in_valid_a = 1'b0; out_ready_a = 1'b0;
      in_valid_b = 1'b0; out_ready_b = 1'b0;
      set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

      // 1: asynchronous reset before any clock edge, then first entry
      #2;
      reset = 1'b1;
      set_in(1'b1, 1'b0, 5'd3, 32'h0000_00AA, 32'h0);
      in_valid_a = 1'b1; out_ready_a = 1'b1;
      #1;
      check("rst_out_valid", out_valid_a, 1'b0);
      check("rst_reg_write", out_reg_write_a, 1'b0);
      check("rst_wb_data", out_wb_data_a, 32'h0);
      check("rst_write_reg", out_write_reg_a, 5'd0);
      check("rst_in_ready_a", in_ready_a, 1'b1);
      check("rst_in_ready_b", in_ready_b, 1'b1);
      @(negedge clk);
      #2 reset = 1'b0;
      tick();
      check("s1_out_valid", out_valid_a, 1'b1);
      check("s1_wb_data", out_wb_data_a, 32'hAA);
      check("s1_reg_write", out_reg_write_a, 1'b1);
      check("s1_write_reg", out_write_reg_a, 5'd3);

      // 2: back-to-back stream, no bubbles
      for (int i = 1; i <= 8; i++) begin
         set_in(1'b1, (i % 2 == 0), 5'(i), 32'(i), 32'h100 + 32'(i));
         tick();
         check("s2_out_valid", out_valid_a, 1'b1);
         check("s2_wb_data", out_wb_data_a, (i % 2 == 0) ? 32'h100 + 32'(i) : 32'(i));
         check("s2_in_ready", in_ready_a, 1'b1);
      end
      in_valid_a = 1'b0;
      tick();
      check("s2_drained", out_valid_a, 1'b0);

      // 3: skid fills while stalled, then drains in order
      out_ready_a = 1'b0;
      set_in(1'b1, 1'b0, 5'd5, 32'h11, 32'h0);
      in_valid_a = 1'b1;
      tick();
      check("s3_a_held", out_wb_data_a, 32'h11);
      check("s3_ready_after_a", in_ready_a, 1'b1);
      set_in(1'b1, 1'b0, 5'd6, 32'h22, 32'h0);
      tick();
      check("s3_a_still", out_wb_data_a, 32'h11);
      check("s3_full_ready", in_ready_a, 1'b0);
      set_in(1'b1, 1'b0, 5'd7, 32'h33, 32'h0);
      tick();
      tick();
      check("s3_c_blocked", out_wb_data_a, 32'h11);
      check("s3_c_ready", in_ready_a, 1'b0);
      check("s3_stall_wreg", out_write_reg_a, 5'd5);
      out_ready_a = 1'b1;
      tick();
      check("s3_b_out", out_wb_data_a, 32'h22);
      check("s3_ready_back", in_ready_a, 1'b1);
      tick();
      check("s3_c_out", out_wb_data_a, 32'h33);
      check("s3_c_valid", out_valid_a, 1'b1);
      in_valid_a = 1'b0;
      tick();
      check("s3_empty", out_valid_a, 1'b0);
      check("s3_empty_ready", in_ready_a, 1'b1);

      // 4: flush of a full stage, and flush discarding an in_fire
      out_ready_a = 1'b0;
      set_in(1'b1, 1'b0, 5'd8, 32'h44, 32'h0);
      in_valid_a = 1'b1;
      tick();
      set_in(1'b1, 1'b0, 5'd9, 32'h55, 32'h0);
      tick();
      check("s4_full", in_ready_a, 1'b0);
      set_in(1'b1, 1'b0, 5'd10, 32'h66, 32'h0);
      flush = 1'b1;
      tick();
      check("s4_flush_valid", out_valid_a, 1'b0);
      check("s4_flush_rw", out_reg_write_a, 1'b0);
      check("s4_flush_ready", in_ready_a, 1'b1);
      tick();
      check("s4_flush_fire", out_valid_a, 1'b0);
      flush = 1'b0;
      in_valid_a = 1'b0;
      out_ready_a = 1'b1;
      tick();
      check("s4_no_ghost", out_valid_a, 1'b0);

      // 5: write to r0 with and without suppression
      set_in(1'b1, 1'b1, 5'd0, 32'h0, 32'hBEEF);
      in_valid_a = 1'b1;
      in_valid_b = 1'b1;
      out_ready_b = 1'b1;
      tick();
      check("s5_valid_a", out_valid_a, 1'b1);
      check("s5_suppress_a", out_reg_write_a, 1'b0);
      check("s5_wb_a", out_wb_data_a, 32'hBEEF);
      check("s5_valid_b", out_valid_b, 1'b1);
      check("s5_nosuppress_b", out_reg_write_b, 1'b1);
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      tick();
      check("s5_empty_b", out_valid_b, 1'b0);

      // 6: single-entry variant, combinational in_ready
      out_ready_b = 1'b0;
      set_in(1'b1, 1'b0, 5'd5, 32'h11, 32'h0);
      in_valid_b = 1'b1;
      tick();
      check("s6_a_held", out_wb_data_b, 32'h11);
      check("s6_stall_ready", in_ready_b, 1'b0);
      set_in(1'b1, 1'b0, 5'd6, 32'h22, 32'h0);
      tick();
      check("s6_b_blocked", out_wb_data_b, 32'h11);
      out_ready_b = 1'b1;
      #1;
      check("s6_ready_comb", in_ready_b, 1'b1);
      tick();
      check("s6_b_out", out_wb_data_b, 32'h22);
      out_ready_b = 1'b0;
      #1;
      check("s6_ready_drop", in_ready_b, 1'b0);
      out_ready_b = 1'b1;
      set_in(1'b1, 1'b0, 5'd7, 32'h33, 32'h0);
      tick();
      check("s6_c_out", out_wb_data_b, 32'h33);
      in_valid_b = 1'b0;
      tick();
      check("s6_empty", out_valid_b, 1'b0);

      // reset asserted mid-cycle during a stall
      out_ready_a = 1'b0;
      set_in(1'b1, 1'b0, 5'd4, 32'h77, 32'h0);
      in_valid_a = 1'b1;
      tick();
      check("mr_held", out_wb_data_a, 32'h77);
      #2 reset = 1'b1;
      #1;
      check("mr_valid", out_valid_a, 1'b0);
      check("mr_wb", out_wb_data_a, 32'h0);
      check("mr_rw", out_reg_write_a, 1'b0);
      check("mr_ready", in_ready_a, 1'b1);
      reset = 1'b0;
      in_valid_a = 1'b0;
      tick();
      check("mr_after", out_valid_a, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_pipe_reg.md
Name: mem_wb_pipe_reg

Overview:
- Parametrised MEM/WB pipeline register for the processor pipeline.
- Sits between the data-memory stage and the register-file write-back, and carries reg_write, mem_to_reg, write_reg, alu_result and read_data.
- Adds a valid/ready handshake, stall, flush, an optional 2-entry skid buffer and a registered write-back mux.
- Replaces the fixed-width, always-loading MEM/WB stage register.

Parameters:
- DATA_W, 32, width of alu_result, read_data and wb_data.
- REG_ADDR_W, 5, width of the destination register index.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- ZERO_REG_SUPPRESS, 1: 1 = out_reg_write is forced to 0 when write_reg == 0.

Ports:
- clk  in  1  clock; all state changes on posedge clk.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous; discards all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_reg_write  in  1  write-enable control.
- in_mem_to_reg  in  1  write-back source select: 1 = read_data, 0 = alu_result.
- in_write_reg  in  REG_ADDR_W  destination register index.
- in_alu_result  in  DATA_W  ALU result.
- in_read_data  in  DATA_W  data-memory read value.
- out_valid  out  1  head entry present.
- out_ready  in  1  write-back consumes this cycle.
- out_reg_write  out  1  gated write enable.
- out_mem_to_reg  out  1  registered select.
- out_write_reg  out  REG_ADDR_W  registered destination index.
- out_alu_result  out  DATA_W  registered ALU result.
- out_read_data  out  DATA_W  registered read data.
- out_wb_data  out  DATA_W  out_mem_to_reg ? out_read_data : out_alu_result.

Behaviour:
- Storage:
  - Head entry H drives all out_* signals.
  - Skid entry S exists only when SKID=1.
  - Each entry holds {valid, reg_write, mem_to_reg, write_reg, alu_result, read_data}.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid = H.valid.
- in_ready:
  - SKID=1: in_ready = ~S.valid (registered; no combinational path from out_ready).
  - SKID=0: in_ready = ~H.valid | out_ready.
- Next-state when H is empty or out_fire:
  - If S.valid: H <= S and S.valid <= 0.
  - Else if in_fire: H <= input.
  - Else: H.valid <= 0.
- Next-state when H is valid and ~out_fire (stall):
  - H holds; all out_* signals stay stable.
  - If in_fire (SKID=1 only): S <= input.
- Ordering is strictly FIFO: S is always older than any new input.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Throughput is 1 entry/cycle when out_ready is held high.
- out_reg_write = H.valid & H.reg_write & ~(ZERO_REG_SUPPRESS & (H.write_reg == 0)).
- out_wb_data is a mux on the registered fields; no added latency.
- Flush:
  - Next cycle, H.valid = 0 and S.valid = 0.
  - An in_fire in the flush cycle is discarded.
  - Flush has priority over every load.
  - Data fields may retain stale values; the gated out_reg_write is 0.
- Reset (asynchronous, any time including mid-stall):
  - All valid bits, control bits and data fields = 0.
  - out_valid = 0, out_reg_write = 0, out_wb_data = 0.
  - in_ready = 1.
  - On reset release, the first posedge behaves as an empty stage.
- Full condition (SKID=1, H and S both valid): in_ready = 0; an in_valid asserted while full is not consumed.
- Simultaneous out_fire and in_fire with S valid: H <= S. in_fire is impossible in this case because in_ready = 0.
- Simultaneous out_fire and in_fire with S empty: H <= input; no bubble.
- out_ready is ignored while out_valid = 0.
- Handshake stability: in_* fields only need to be stable while in_valid & ~in_ready.

Test Plan:
1. Reset pulse mid-cycle, then in_valid=1, write_reg=3, alu=0x0000_00AA, mem_to_reg=0, reg_write=1, out_ready=1 -> after reset all outputs are 0 and in_ready=1. One cycle later out_valid=1, out_wb_data=0xAA, out_reg_write=1, out_write_reg=3.
2. Back-to-back stream of 8 entries (alu=1..8, mem_to_reg alternating, read_data=0x100+i), out_ready=1 -> out_wb_data follows 1, 0x102, 3, 0x104, ... with no bubbles, each 1 cycle after input.
3. SKID=1, out_ready=0 while feeding A=0x11, B=0x22, C=0x33 -> A held in H and B in S; in_ready=0 after B; C is not consumed. Raise out_ready -> outputs 0x11, 0x22, 0x33 in order, in_ready returns to 1.
4. Flush while H and S are full and in_valid=1 -> next cycle out_valid=0, out_reg_write=0, in_ready=1; the flushed entries never appear on the output.
5. Entry with reg_write=1, write_reg=0, ZERO_REG_SUPPRESS=1 -> out_valid=1, out_reg_write=0. With ZERO_REG_SUPPRESS=0 -> out_reg_write=1.
6. SKID=0, same stimulus as scenario 3 -> in_ready tracks out_ready combinationally while H is valid; only A is held. B is accepted in the same cycle out_ready rises, and order A, B, C is preserved.
